// File: rtl/nios_pio_pkg.sv
// Shared definitions for the Nios II PIO slaves: word address map, edge-type encoding
// and a width helper for counters.
package nios_pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_DIR     = 2'd1;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_type_e;

    // Bits needed to hold values 0..v-1; never less than one bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/nios_pio_debounce.sv
// Single-bit debounce filter: q follows d only after d has held a new level for
// DEBOUNCE_CYCLES consecutive clocks; load forces q to d immediately.
module nios_pio_debounce
    import nios_pio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic d,
    output logic q
);

    localparam int CW = clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q   <= 1'b0;
            cnt <= '0;
        end else if (load) begin
            q   <= d;
            cnt <= '0;
        end else if (d == q) begin
            // Input back at the filtered level: any partial count is discarded.
            cnt <= '0;
        end else if (cnt == LAST) begin
            q   <= d;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/nios_system_keys_in.sv
// Avalon-MM input PIO with per-bit edge capture and masked level IRQ.
// Optional debounce filter enabled by defining NIOS_PIO_DEBOUNCE_EN.
module nios_system_keys_in
    import nios_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int EDGE_TYPE       = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int WARM_N = SYNC_STAGES + 1;
    localparam int WARM_W = clog2(WARM_N + 1);
    localparam edge_type_e EDGE_SEL = edge_type_e'(EDGE_TYPE);

    logic [WIDTH-1:0] sync_r [SYNC_STAGES];
    logic [WIDTH-1:0] sync_q, filt_q, prev_q, edges;
    logic [WIDTH-1:0] irqmask, edgecap, wd, clr_mask;
    logic [WARM_W-1:0] warm_cnt;
    logic warm_done, load, wr_en;
    logic [31:0] rd_next;
    logic unused_wd;

    assign sync_q    = sync_r[SYNC_STAGES-1];
    assign warm_done = (warm_cnt == WARM_W'(WARM_N));
    assign load      = (warm_cnt == WARM_W'(SYNC_STAGES));
    assign wr_en     = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= '0;
        end else begin
            sync_r[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
        end
    end

    // Warm-up: edges are ignored until the chain and history flop hold real input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        warm_cnt <= '0;
        else if (!warm_done) warm_cnt <= warm_cnt + 1'b1;
    end

`ifdef NIOS_PIO_DEBOUNCE_EN
    for (genvar g = 0; g < WIDTH; g++) begin : g_db
        nios_pio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk     (clk),
            .reset_n (reset_n),
            .load    (load),
            .d       (sync_q[g]),
            .q       (filt_q[g])
        );
    end
`else
    assign filt_q = sync_q;
`endif

    // History flop is preloaded alongside the filter so warm-up end is edge-free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  prev_q <= '0;
        else if (load) prev_q <= sync_q;
        else           prev_q <= filt_q;
    end

    always_comb begin
        edges = '0;
        if (warm_done) begin
            case (EDGE_SEL)
                EDGE_RISE: edges = filt_q & ~prev_q;
                EDGE_FALL: edges = ~filt_q & prev_q;
                default:   edges = filt_q ^ prev_q;
            endcase
        end
        clr_mask = (wr_en && address == PIO_ADDR_EDGECAP) ? wd : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask <= '0;
            edgecap <= '0;
            irq     <= 1'b0;
        end else begin
            if (wr_en && address == PIO_ADDR_IRQMASK) irqmask <= wd;
            // A fresh edge wins over a same-cycle clear of that bit.
            edgecap <= (edgecap & ~clr_mask) | edges;
            irq     <= |(edgecap & irqmask);
        end
    end

    always_comb begin
        rd_next = '0;
        case (address)
            PIO_ADDR_DATA:    rd_next[WIDTH-1:0] = filt_q;
            PIO_ADDR_IRQMASK: rd_next[WIDTH-1:0] = irqmask;
            PIO_ADDR_EDGECAP: rd_next[WIDTH-1:0] = edgecap;
            default:          rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_next;
    end

endmodule
